// File: rtl/int_div_arb.sv
// Round-robin front end that shares one iterative unsigned divider among NREQ requesters,
// adding signed fix-up, divide-by-zero/overflow bypass and a held valid/ready response port.
module int_div_arb #(
    parameter  int WIDTH = 32,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NREQ-1:0]         req_valid_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic [2*NREQ-1:0]       req_op_i,
    input  logic [WIDTH*NREQ-1:0]   req_a_i,
    input  logic [WIDTH*NREQ-1:0]   req_b_i,
    input  logic                    flush_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [IDW-1:0]          rsp_id_o,
    output logic [WIDTH-1:0]        rsp_data_o,
    output logic                    div_start_o,
    output logic [WIDTH-1:0]        div_n_o,
    output logic [WIDTH-1:0]        div_d_o,
    input  logic [WIDTH-1:0]        div_q_i,
    input  logic [WIDTH-1:0]        div_r_i,
    input  logic                    div_valid_i,
    output logic [2:0]              dbg_state_o
);

    // Handshakes: a request transfers in the cycle req_valid_i[k] and req_ready_o[k] are both
    // high; a response transfers in the cycle rsp_valid_o and rsp_ready_i are both high, and
    // rsp_valid_o/rsp_id_o/rsp_data_o hold steady until then (or until flush_i drops them).
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    logic [IDW-1:0]   r_rr;
    logic [IDW-1:0]   r_id;
    logic             r_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div_start;
    logic [WIDTH-1:0] r_div_n;
    logic [WIDTH-1:0] r_div_d;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;

    logic             w_any;
    logic [IDW-1:0]   w_grant;
    logic [IDW:0]     w_idx_ext;
    logic [1:0]       w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_sgn;
    logic             w_b_zero;
    logic             w_ovf;
    logic [WIDTH-1:0] w_spec_data;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic [IDW-1:0]   w_rr_next;

    // Scan from the highest offset down so the first valid at or after r_rr wins.
    always_comb begin
        w_any     = 1'b0;
        w_grant   = '0;
        w_idx_ext = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_idx_ext = {1'b0, r_rr} + (IDW+1)'(i);
            if (w_idx_ext >= (IDW+1)'(NREQ)) begin
                w_idx_ext = w_idx_ext - (IDW+1)'(NREQ);
            end
            if (req_valid_i[w_idx_ext[IDW-1:0]]) begin
                w_any   = 1'b1;
                w_grant = w_idx_ext[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (r_state == S_IDLE && w_any) begin
            req_ready_o[w_grant] = 1'b1;
        end
    end

    assign w_sel_op = req_op_i[w_grant*2 +: 2];
    assign w_sel_a  = req_a_i[w_grant*WIDTH +: WIDTH];
    assign w_sel_b  = req_b_i[w_grant*WIDTH +: WIDTH];
    assign w_sgn    = w_sel_op[0];
    assign w_b_zero = (w_sel_b == '0);
    assign w_ovf    = w_sgn && (w_sel_a == MIN_VAL) && (w_sel_b == '1);

    always_comb begin
        w_spec_data = '0;
        if (w_b_zero) begin
            w_spec_data = w_sel_op[1] ? w_sel_a : '1;
        end else if (w_ovf) begin
            w_spec_data = w_sel_op[1] ? '0 : MIN_VAL;
        end
    end

    // Negating MIN wraps back to MIN, which is exactly its magnitude read as unsigned.
    assign w_abs_a = (w_sgn && w_sel_a[WIDTH-1]) ? -w_sel_a : w_sel_a;
    assign w_abs_b = (w_sgn && w_sel_b[WIDTH-1]) ? -w_sel_b : w_sel_b;
    assign w_q_fix = r_neg_q ? -div_q_i : div_q_i;
    assign w_r_fix = r_neg_r ? -div_r_i : div_r_i;
    assign w_rr_next = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= S_IDLE;
            r_rr        <= '0;
            r_id        <= '0;
            r_rem       <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_div_start <= 1'b0;
            r_div_n     <= '0;
            r_div_d     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id    <= w_grant;
                        r_rem   <= w_sel_op[1];
                        r_neg_q <= w_sgn && (w_sel_a[WIDTH-1] ^ w_sel_b[WIDTH-1]);
                        r_neg_r <= w_sgn && w_sel_a[WIDTH-1];
                        if (w_b_zero || w_ovf) begin
                            r_rsp_data  <= w_spec_data;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_div_n     <= w_abs_a;
                            r_div_d     <= w_abs_b;
                            r_div_start <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_div_start <= 1'b0;
                    r_state     <= flush_i ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (flush_i) begin
                        r_state <= div_valid_i ? S_IDLE : S_DRAIN;
                    end else if (div_valid_i) begin
                        r_rsp_data  <= r_rem ? w_r_fix : w_q_fix;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_DRAIN: begin
                    if (div_valid_i) begin
                        r_state <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (flush_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_rr        <= w_rr_next;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_id_o    = r_id;
    assign rsp_data_o  = r_rsp_data;
    assign div_start_o = r_div_start;
    assign div_n_o     = r_div_n;
    assign div_d_o     = r_div_d;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_int_div_arb.sv
// Directed bench for int_div_arb with a behavioural iterative divider attached to the divider port.
module tb_int_div_arb;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready_o;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  flush;
    logic                  rsp_valid_o;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id_o;
    logic [WIDTH-1:0]      rsp_data_o;
    logic                  div_start_o;
    logic [WIDTH-1:0]      div_n_o;
    logic [WIDTH-1:0]      div_d_o;
    logic [WIDTH-1:0]      div_q;
    logic [WIDTH-1:0]      div_r;
    logic                  div_valid;
    logic [2:0]            dbg_state_o;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t_acc  = 0;
    int n_start = 0;
    int n_rsp_seen = 0;
    int onehot_err = 0;
    logic mon_en = 1'b0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] grant_q[$];
    logic [WIDTH-1:0] id_q[$];
    logic [WIDTH-1:0] data_q[$];

    int_div_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk_i(clk), .reset_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
        .flush_i(flush),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
        .div_start_o(div_start_o), .div_n_o(div_n_o), .div_d_o(div_d_o),
        .div_q_i(div_q), .div_r_i(div_r), .div_valid_i(div_valid),
        .dbg_state_o(dbg_state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: valid pulses in the WIDTH+3rd cycle counting the start cycle as the first.
    logic [WIDTH-1:0] m_n, m_d;
    int   m_cnt;
    logic m_busy;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_cnt <= 0; div_valid <= 1'b0;
            div_q <= '0; div_r <= '0; m_n <= '0; m_d <= '0;
        end else begin
            div_valid <= 1'b0;
            if (div_start_o) begin
                m_busy <= 1'b1; m_cnt <= 0; m_n <= div_n_o; m_d <= div_d_o;
            end else if (m_busy) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == WIDTH) begin
                    m_busy    <= 1'b0;
                    div_valid <= 1'b1;
                    div_q     <= (m_d == '0) ? '1 : m_n / m_d;
                    div_r     <= (m_d == '0) ? m_n : m_n % m_d;
                end
            end
        end
    end

    always @(posedge clk) if (div_start_o) n_start <= n_start + 1;

    always @(negedge clk) begin
        if (rsp_valid_o) n_rsp_seen <= n_rsp_seen + 1;
        if (mon_en) begin
            if ($countones(req_ready_o) > 1) onehot_err <= onehot_err + 1;
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready_o[i]) grant_q.push_back(WIDTH'(i));
            end
            if (rsp_valid_o && rsp_ready) begin
                id_q.push_back(WIDTH'(rsp_id_o));
                data_q.push_back(rsp_data_o);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input string tag, input int k, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [NREQ-1:0] exp_rdy;
        req_op[k*2 +: 2]        = op;
        req_a[k*WIDTH +: WIDTH] = a;
        req_b[k*WIDTH +: WIDTH] = b;
        req_valid[k]            = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (|req_ready_o) break;
        end
        exp_rdy    = '0;
        exp_rdy[k] = 1'b1;
        chk({tag, "_rdy"}, 32'(req_ready_o), 32'(exp_rdy));
        t_acc = cyc;
        tick();
        req_valid[k] = 1'b0;
    endtask

    task automatic await_rsp(input string tag, input int exp_id, input logic [31:0] exp_data,
                             input int exp_lat);
        int lat;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                lat = cyc - t_acc;
                break;
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_id"}, 32'(rsp_id_o), 32'(exp_id));
        chk({tag, "_data"}, rsp_data_o, exp_data);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready_o), 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id_o), 32'd0);
        chk({tag, "_rsp_data"}, rsp_data_o, 32'd0);
        chk({tag, "_div_start"}, 32'(div_start_o), 32'd0);
        chk({tag, "_div_n"}, div_n_o, 32'd0);
        chk({tag, "_div_d"}, div_d_o, 32'd0);
        chk({tag, "_state"}, 32'(dbg_state_o), 32'd0);
    endtask

    initial begin
        int s0, r0, h, bad;
        rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        flush = 1'b0; rsp_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Signed divide with negative dividend, through the divider.
        s0 = n_start;
        accept("div_m7_2", 0, 2'b01, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2_start", 32'(div_start_o), 32'd1);
        chk("div_m7_2_n", div_n_o, 32'd7);
        chk("div_m7_2_d", div_d_o, 32'd2);
        await_rsp("div_m7_2", 0, 32'hFFFF_FFFD, 36);
        chk("div_m7_2_nstart", 32'(n_start - s0), 32'd1);
        accept("rem_m7_2", 0, 2'b11, 32'hFFFF_FFF9, 32'd2);
        await_rsp("rem_m7_2", 0, 32'hFFFF_FFFF, 36);

        // Divide by zero bypass.
        s0 = n_start;
        accept("divu_z", 1, 2'b00, 32'd100, 32'd0);
        await_rsp("divu_z", 1, 32'hFFFF_FFFF, 1);
        accept("remu_z", 1, 2'b10, 32'd100, 32'd0);
        await_rsp("remu_z", 1, 32'd100, 1);
        chk("divz_nstart", 32'(n_start - s0), 32'd0);

        // Signed overflow bypass.
        s0 = n_start;
        accept("div_ovf", 2, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        await_rsp("div_ovf", 2, 32'h8000_0000, 1);
        accept("rem_ovf", 2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        await_rsp("rem_ovf", 2, 32'd0, 1);
        chk("ovf_nstart", 32'(n_start - s0), 32'd0);

        // More signed/unsigned patterns.
        accept("div_20_m3", 3, 2'b01, 32'd20, 32'hFFFF_FFFD);
        chk("div_20_m3_d", div_d_o, 32'd3);
        await_rsp("div_20_m3", 3, 32'hFFFF_FFFA, 36);
        accept("rem_20_m3", 3, 2'b11, 32'd20, 32'hFFFF_FFFD);
        await_rsp("rem_20_m3", 3, 32'd2, 36);
        accept("rem_m5_z", 3, 2'b11, 32'hFFFF_FFFB, 32'd0);
        await_rsp("rem_m5_z", 3, 32'hFFFF_FFFB, 1);
        accept("divu_big", 3, 2'b00, 32'hFFFF_FFFF, 32'h10);
        chk("divu_big_n", div_n_o, 32'hFFFF_FFFF);
        await_rsp("divu_big", 3, 32'h0FFF_FFFF, 36);
        accept("remu_big", 3, 2'b10, 32'hFFFF_FFFF, 32'h10);
        await_rsp("remu_big", 3, 32'h0000_000F, 36);

        // Response stall: outputs hold, no accept until the handshake.
        accept("stall", 3, 2'b00, 32'd1000, 32'd7);
        req_op[1:0] = 2'b00; req_a[31:0] = 32'd50; req_b[31:0] = 32'd0;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid_o) break;
        end
        chk("stall_lat", 32'(cyc - t_acc), 32'd36);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid_o || rsp_data_o !== 32'd142 || rsp_id_o !== 2'd3 || req_ready_o !== '0)
                bad++;
        end
        chk("stall_hold", 32'(bad), 32'd0);
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        h = cyc;
        accept("after_stall", 0, 2'b00, 32'd50, 32'd0);
        chk("after_stall_cyc", 32'(t_acc - h), 32'd0);
        await_rsp("after_stall", 0, 32'hFFFF_FFFF, 1);

        // Flush in WAIT: no response, next accept only once the divider drains.
        accept("flush", 1, 2'b00, 32'd1000, 32'd3);
        h = t_acc;
        repeat (4) tick();
        chk("flush_wait_state", 32'(dbg_state_o), 32'd2);
        flush = 1'b1;
        r0 = n_rsp_seen;
        tick();
        flush = 1'b0;
        chk("flush_drain_state", 32'(dbg_state_o), 32'd3);
        accept("post_flush", 2, 2'b00, 32'd9, 32'd0);
        chk("post_flush_cyc", 32'(t_acc - h), 32'd36);
        chk("flush_no_rsp", 32'(n_rsp_seen - r0), 32'd0);
        await_rsp("post_flush", 2, 32'hFFFF_FFFF, 1);

        // Asynchronous reset in the middle of WAIT.
        accept("rst_mid", 3, 2'b00, 32'd77, 32'd5);
        repeat (9) tick();
        chk("rst_mid_state", 32'(dbg_state_o), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst_mid");
        tick();
        rst_n = 1'b1;
        tick();

        // Round robin with every requester active and the consumer always ready.
        for (int k = 0; k < NREQ; k++) begin
            req_op[k*2 +: 2]        = 2'b00;
            req_a[k*WIDTH +: WIDTH] = 32'(k * 10 + 7);
            req_b[k*WIDTH +: WIDTH] = 32'(k + 1);
        end
        exp_q = '{32'd7, 32'd8, 32'd9, 32'd9, 32'd7};
        rsp_ready = 1'b1;
        mon_en    = 1'b1;
        req_valid = '1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (id_q.size() >= 5) break;
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        mon_en = 1'b0;
        chk("rr_grant_cnt", 32'(grant_q.size()), 32'd5);
        chk("rr_rsp_cnt", 32'(id_q.size()), 32'd5);
        chk("rr_onehot", 32'(onehot_err), 32'd0);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_q.size()) chk($sformatf("rr_grant%0d", i), grant_q[i], 32'(i % NREQ));
            if (i < id_q.size())    chk($sformatf("rr_id%0d", i), id_q[i], 32'(i % NREQ));
            if (i < data_q.size())  chk($sformatf("rr_data%0d", i), data_q[i], exp_q[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
